// File: rtl/clk_freq_meter_pkg.sv
// Shared definitions for the clock frequency meter: FSM encoding and
// synchronizer limits.
package clk_freq_meter_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_MEAS = 2'd2,
      ST_DONE = 2'd3
   } meter_state_t;

   // Fewer than two flops leaves too much metastability exposure on clk_meas.
   localparam int unsigned MIN_SYNC_STAGES = 2;

   function automatic int unsigned clamp_sync_stages(input int unsigned stages);
      return (stages < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : stages;
   endfunction

endpackage

// File: rtl/clk_freq_meter_sync_edge_det.sv
// Multi-flop synchronizer for an asynchronous input plus a rising-edge
// detector on the synchronized level.
module sync_edge_det
   import clk_freq_meter_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic reset_n,
   input  logic din,
   output logic meas_s,
   output logic rise
);

   localparam int unsigned STAGES = clamp_sync_stages(SYNC_STAGES);

   logic [STAGES-1:0] sync_q;
   logic              meas_d;

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= '0;
         meas_d <= 1'b0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], din};
         meas_d <= sync_q[STAGES-1];
      end
   end

   assign meas_s = sync_q[STAGES-1];
   assign rise   = meas_s & ~meas_d;

endmodule

// File: rtl/clk_freq_meter.sv
// Measures period and high time of clk_meas in clk_i cycles, with a
// programmable timeout and counter-saturation abort.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   IDLE    | waiting for start; timeout counter held clear
//   ARM     | waiting for the first synchronized rising edge
//   MEAS    | counting period/high time until the next rising edge
//   DONE    | one-cycle completion; results and err already loaded
module clk_freq_meter
   import clk_freq_meter_pkg::*;
#(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic             clk_i,
   input  logic             reset_n,
   input  logic             clk_meas,
   input  logic             start,
   input  logic [CNT_W-1:0] timeout,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [CNT_W-1:0] period,
   output logic [CNT_W-1:0] high_time
);

   localparam logic [CNT_W-1:0] CNT_SAT  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = '0;

   meter_state_t state, next_state;

   logic             meas_s;
   logic             rise;
   logic [CNT_W-1:0] pcnt;
   logic [CNT_W-1:0] hcnt;
   logic [CNT_W-1:0] tcnt;
   logic [CNT_W-1:0] tcnt_now;
   logic [CNT_W-1:0] tcnt_next;
   logic             timeout_hit;
   logic             arm_abort;
   logic             meas_abort;

   sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk_i   (clk_i),
      .reset_n (reset_n),
      .din     (clk_meas),
      .meas_s  (meas_s),
      .rise    (rise)
   );

   // tcnt holds the count of completed busy cycles, so the value seen in the
   // current cycle is tcnt + 1 (1 on the first ARM cycle). It sticks at
   // all-ones rather than wrapping so a long ARM phase cannot re-fire timeout.
   assign tcnt_now    = tcnt + CNT_ONE;
   assign tcnt_next   = (tcnt == CNT_SAT) ? tcnt : tcnt_now;
   assign timeout_hit = (timeout != CNT_ZERO) && (tcnt_now == timeout);

   // In ARM pcnt is not running yet, so a stuck clock with timeout disabled
   // is bounded by tcnt reaching all-ones instead.
   assign arm_abort  = timeout_hit || (tcnt_now == CNT_SAT);
   assign meas_abort = timeout_hit || (pcnt == CNT_SAT);

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: if (start) next_state = ST_ARM;
         ST_ARM: begin
            if (arm_abort)  next_state = ST_DONE;
            else if (rise)  next_state = ST_MEAS;
         end
         ST_MEAS: begin
            if (rise || meas_abort) next_state = ST_DONE;
         end
         ST_DONE: next_state = ST_IDLE;
         default: next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state)
         ST_ARM,
         ST_MEAS: busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i or negedge reset_n) begin
      if (!reset_n) begin
         tcnt      <= '0;
         pcnt      <= '0;
         hcnt      <= '0;
         err       <= 1'b0;
         period    <= '0;
         high_time <= '0;
      end else begin
         case (state)
            ST_IDLE: tcnt <= '0;
            ST_ARM: begin
               tcnt <= tcnt_next;
               if (arm_abort) begin
                  err       <= 1'b1;
                  period    <= '0;
                  high_time <= '0;
               end else if (rise) begin
                  pcnt <= CNT_ONE;
                  hcnt <= CNT_ONE;
               end
            end
            ST_MEAS: begin
               tcnt <= tcnt_next;
               // A completing edge beats a simultaneous timeout or saturation.
               if (rise) begin
                  err       <= 1'b0;
                  period    <= pcnt;
                  high_time <= hcnt;
               end else if (meas_abort) begin
                  err       <= 1'b1;
                  period    <= '0;
                  high_time <= '0;
               end else begin
                  pcnt <= pcnt + CNT_ONE;
                  hcnt <= hcnt + {{(CNT_W-1){1'b0}}, meas_s};
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_clk_freq_meter.sv
// Directed bench for clk_freq_meter: nominal clocks, back-to-back runs,
// timeouts, saturation, reset mid-measurement and edge/timeout coincidence.
module tb_clk_freq_meter;

   logic        clk_i = 1'b0;
   logic        reset_n = 1'b0;
   logic        clk_meas;
   logic        start = 1'b0;
   logic [31:0] timeout = 32'd0;
   logic        busy, done, err;
   logic [31:0] period, high_time;

   logic        start8 = 1'b0;
   logic        meas8 = 1'b0;
   logic [7:0]  timeout8 = 8'd0;
   logic        busy8, done8, err8;
   logic [7:0]  period8, high8;

   logic        man_mode = 1'b1;
   logic        man_val = 1'b0;
   logic        gen_meas = 1'b0;
   int          gen_cnt = 1;
   int          gen_hi = 5;
   int          gen_lo = 5;

   int          cyc = 0;
   int          start_cyc = 0;
   int          checks = 0;
   int          passes = 0;
   int          lat;

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   always @(posedge clk_i) begin
      if (gen_cnt <= 1) begin
         gen_meas <= ~gen_meas;
         gen_cnt  <= gen_meas ? gen_lo : gen_hi;
      end else begin
         gen_cnt <= gen_cnt - 1;
      end
   end

   assign clk_meas = man_mode ? man_val : gen_meas;

   clk_freq_meter u_dut (
      .clk_i     (clk_i),
      .reset_n   (reset_n),
      .clk_meas  (clk_meas),
      .start     (start),
      .timeout   (timeout),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .period    (period),
      .high_time (high_time)
   );

   clk_freq_meter #(.CNT_W(8)) u_dut8 (
      .clk_i     (clk_i),
      .reset_n   (reset_n),
      .clk_meas  (meas8),
      .start     (start8),
      .timeout   (timeout8),
      .busy      (busy8),
      .done      (done8),
      .err       (err8),
      .period    (period8),
      .high_time (high8)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk_i);
         #1;
      end
   endtask

   // start is high for exactly the cycle recorded as start_cyc
   task automatic pulse_start();
      step(1);
      start     = 1'b1;
      start_cyc = cyc;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max_cyc, output int latency);
      int n;
      n = 0;
      while (done !== 1'b1 && n < max_cyc) begin
         step(1);
         n++;
      end
      latency = cyc - start_cyc;
      chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
   endtask

   initial begin
      #2;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_err", {31'd0, err}, 32'd0);
      chk("rst_period", period, 32'd0);
      chk("rst_high", high_time, 32'd0);
      step(2);
      reset_n = 1'b1;

      // 10-cycle clock, 50% duty
      man_mode = 1'b0;
      gen_hi = 5; gen_lo = 5;
      timeout = 32'd100;
      step(20);
      pulse_start();
      chk("t1_busy_after_start", {31'd0, busy}, 32'd1);
      wait_done("t1", 60, lat);
      chk("t1_period", period, 32'd10);
      chk("t1_high", high_time, 32'd5);
      chk("t1_err", {31'd0, err}, 32'd0);
      chk("t1_busy_with_done", {31'd0, busy}, 32'd0);
      step(1);
      chk("t1_done_one_cycle", {31'd0, done}, 32'd0);

      // 3 high / 7 low, back-to-back with start in the cycle after done
      gen_hi = 3; gen_lo = 7;
      step(25);
      pulse_start();
      wait_done("b2b_a", 60, lat);
      chk("b2b_a_period", period, 32'd10);
      chk("b2b_a_high", high_time, 32'd3);
      pulse_start();
      chk("b2b_b_accepted", {31'd0, busy}, 32'd1);
      wait_done("b2b_b", 60, lat);
      chk("b2b_b_period", period, 32'd10);
      chk("b2b_b_high", high_time, 32'd3);
      chk("b2b_b_err", {31'd0, err}, 32'd0);

      // stuck low, then stuck high, timeout 20
      man_mode = 1'b1;
      man_val = 1'b0;
      timeout = 32'd20;
      step(6);
      pulse_start();
      wait_done("to_low", 40, lat);
      chk("to_low_latency", lat, 32'd21);
      chk("to_low_err", {31'd0, err}, 32'd1);
      chk("to_low_period", period, 32'd0);
      chk("to_low_high", high_time, 32'd0);
      man_val = 1'b1;
      step(6);
      pulse_start();
      wait_done("to_high", 40, lat);
      chk("to_high_latency", lat, 32'd21);
      chk("to_high_err", {31'd0, err}, 32'd1);
      chk("to_high_period", period, 32'd0);

      // completing rise lands on tcnt == timeout (cycle 14): edge wins
      man_val = 1'b0;
      timeout = 32'd14;
      step(6);
      pulse_start();
      man_val = 1'b0;
      step(1);
      man_val = 1'b1;
      step(5);
      man_val = 1'b0;
      step(5);
      man_val = 1'b1;
      step(3);
      chk("coin_done", {31'd0, done}, 32'd1);
      chk("coin_err", {31'd0, err}, 32'd0);
      chk("coin_period", period, 32'd10);
      chk("coin_high", high_time, 32'd5);

      // reset asserted during MEAS
      man_val = 1'b0;
      timeout = 32'd0;
      step(6);
      pulse_start();
      step(1);
      man_val = 1'b1;
      step(6);
      chk("rstm_busy_before", {31'd0, busy}, 32'd1);
      reset_n = 1'b0;
      #1;
      chk("rstm_busy", {31'd0, busy}, 32'd0);
      chk("rstm_done", {31'd0, done}, 32'd0);
      chk("rstm_err", {31'd0, err}, 32'd0);
      chk("rstm_period", period, 32'd0);
      chk("rstm_high", high_time, 32'd0);
      step(2);
      reset_n = 1'b1;
      man_mode = 1'b0;
      gen_hi = 5; gen_lo = 5;
      timeout = 32'd100;
      step(25);
      pulse_start();
      wait_done("rstm_after", 60, lat);
      chk("rstm_after_period", period, 32'd10);
      chk("rstm_after_high", high_time, 32'd5);

      // rise on the ARM timeout cycle (4): timeout wins, nothing measured
      man_mode = 1'b1;
      man_val = 1'b0;
      timeout = 32'd4;
      step(6);
      pulse_start();
      step(1);
      man_val = 1'b1;
      step(3);
      chk("armto_done", {31'd0, done}, 32'd1);
      chk("armto_err", {31'd0, err}, 32'd1);
      chk("armto_period", period, 32'd0);
      man_val = 1'b0;

      // 8-bit counters, timeout disabled, static clock: saturation at 255
      step(3);
      start8 = 1'b1;
      start_cyc = cyc;
      step(1);
      start8 = 1'b0;
      step(10);
      start8 = 1'b1;
      step(1);
      start8 = 1'b0;
      begin
         int n;
         n = 0;
         while (done8 !== 1'b1 && n < 400) begin
            step(1);
            n++;
         end
      end
      chk("sat_done_seen", {31'd0, done8}, 32'd1);
      chk("sat_latency", cyc - start_cyc, 32'd256);
      chk("sat_err", {31'd0, err8}, 32'd1);
      chk("sat_period", {24'd0, period8}, 32'd0);
      chk("sat_high", {24'd0, high8}, 32'd0);
      step(1);
      chk("sat_no_restart", {31'd0, busy8}, 32'd0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
